axi_lite_to_apb_bridge: RTL and testbench

- Downstream consumer of an AXI-Lite master port, e.g. the lite side of the AXI-to-AXI-Lite converter; turns AXI-Lite reads and writes into single APB4 transfers for one APB completer.
- Only one APB transfer is in flight at a time.
- Responses are held in one-entry B and R buffers.
- An optional watchdog terminates APB transfers that never complete.

---
 rtl/axi_lite_to_apb_bridge.sv | 189 ++++++++++++++++++
 tb/tb_axi_lite_to_apb_bridge.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_to_apb_bridge.sv
// AXI-Lite slave to single-completer APB4 master, one transfer in flight, one-entry B/R buffers.
// Latency: handshake edge N, SETUP N+1, ACCESS N+2, response valid N+3 with zero wait states.
// Backpressure: a full B or R buffer blocks only new requests of its own direction.
module axi_lite_to_apb_bridge #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [AddrWidth-1:0]   aw_addr_i,
    input  logic [2:0]             aw_prot_i,
    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [DataWidth-1:0]   w_data_i,
    input  logic [DataWidth/8-1:0] w_strb_i,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    output logic [1:0]             b_resp_o,
    output logic                   b_valid_o,
    input  logic                   b_ready_i,
    input  logic [AddrWidth-1:0]   ar_addr_i,
    input  logic [2:0]             ar_prot_i,
    input  logic                   ar_valid_i,
    output logic                   ar_ready_o,
    output logic [DataWidth-1:0]   r_data_o,
    output logic [1:0]             r_resp_o,
    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    output logic [AddrWidth-1:0]   paddr_o,
    output logic [2:0]             pprot_o,
    output logic                   psel_o,
    output logic                   penable_o,
    output logic                   pwrite_o,
    output logic [DataWidth-1:0]   pwdata_o,
    output logic [DataWidth/8-1:0] pstrb_o,
    input  logic                   pready_i,
    input  logic [DataWidth-1:0]   prdata_i,
    input  logic                   pslverr_i
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned CntWidth  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntWidth-1:0] CntLast =
        (TimeoutCycles > 0) ? CntWidth'(TimeoutCycles - 1) : '0;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e                 state_q, state_d;
    logic                   prio_wr_q, prio_wr_d;
    logic                   psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [AddrWidth-1:0]   paddr_q, paddr_d;
    logic [2:0]             pprot_q, pprot_d;
    logic [DataWidth-1:0]   pwdata_q, pwdata_d;
    logic [StrbWidth-1:0]   pstrb_q, pstrb_d;
    logic                   b_valid_q, b_valid_d, r_valid_q, r_valid_d;
    logic [1:0]             b_resp_q, b_resp_d, r_resp_q, r_resp_d;
    logic [DataWidth-1:0]   r_data_q, r_data_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;

    logic wr_req, rd_req, grant_wr, grant_rd, timeout;

    // Requests look only at registered buffer state, so a draining buffer still blocks.
    assign wr_req   = aw_valid_i & w_valid_i & ~b_valid_q;
    assign rd_req   = ar_valid_i & ~r_valid_q;
    assign grant_wr = (state_q == IDLE) & wr_req & (~rd_req | prio_wr_q);
    assign grant_rd = (state_q == IDLE) & rd_req & (~wr_req | ~prio_wr_q);
    assign timeout  = (TimeoutCycles != 0) && (cnt_q == CntLast);

    always_comb begin
        state_d   = state_q;
        prio_wr_d = prio_wr_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pprot_d   = pprot_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        b_valid_d = b_valid_q;
        b_resp_d  = b_resp_q;
        r_valid_d = r_valid_q;
        r_resp_d  = r_resp_q;
        r_data_d  = r_data_q;
        cnt_d     = cnt_q;

        if (b_valid_q && b_ready_i) b_valid_d = 1'b0;
        if (r_valid_q && r_ready_i) r_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = 1'b1;
                    paddr_d  = aw_addr_i;
                    pprot_d  = aw_prot_i;
                    pwdata_d = w_data_i;
                    pstrb_d  = w_strb_i;
                    if (rd_req) prio_wr_d = 1'b0;
                end else if (grant_rd) begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = 1'b0;
                    paddr_d  = ar_addr_i;
                    pprot_d  = ar_prot_i;
                    pstrb_d  = '0;
                    if (wr_req) prio_wr_d = 1'b1;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                // A watchdog expiry completes the transfer exactly like an erroring completer.
                if (pready_i || timeout) begin
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (pwrite_q) begin
                        b_valid_d = 1'b1;
                        b_resp_d  = (pslverr_i || !pready_i) ? 2'b10 : 2'b00;
                    end else begin
                        r_valid_d = 1'b1;
                        r_data_d  = pready_i ? prdata_i : '0;
                        r_resp_d  = (pslverr_i || !pready_i) ? 2'b10 : 2'b00;
                    end
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            prio_wr_q <= 1'b1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pprot_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            b_valid_q <= 1'b0;
            b_resp_q  <= '0;
            r_valid_q <= 1'b0;
            r_resp_q  <= '0;
            r_data_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            prio_wr_q <= prio_wr_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pprot_q   <= pprot_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            b_valid_q <= b_valid_d;
            b_resp_q  <= b_resp_d;
            r_valid_q <= r_valid_d;
            r_resp_q  <= r_resp_d;
            r_data_q  <= r_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign aw_ready_o = grant_wr;
    assign w_ready_o  = grant_wr;
    assign ar_ready_o = grant_rd;
    assign b_valid_o  = b_valid_q;
    assign b_resp_o   = b_resp_q;
    assign r_valid_o  = r_valid_q;
    assign r_resp_o   = r_resp_q;
    assign r_data_o   = r_data_q;
    assign psel_o     = psel_q;
    assign penable_o  = penable_q;
    assign pwrite_o   = pwrite_q;
    assign paddr_o    = paddr_q;
    assign pprot_o    = pprot_q;
    assign pwdata_o   = pwdata_q;
    assign pstrb_o    = pstrb_q;

endmodule

// File: tb/tb_axi_lite_to_apb_bridge.sv
// Directed bench for axi_lite_to_apb_bridge with a configurable APB completer model.
module tb_axi_lite_to_apb_bridge;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] aw_addr, w_data, ar_addr, r_data, paddr, pwdata, prdata;
    logic [2:0]  aw_prot, ar_prot, pprot;
    logic [3:0]  w_strb, pstrb;
    logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_valid, r_ready;
    logic [1:0]  b_resp, r_resp;
    logic        psel, penable, pwrite, pready, pslverr;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cfg_wait = 0;
    bit          cfg_hang = 1'b0;
    bit          cfg_err  = 1'b0;
    logic [31:0] cfg_rdata = 32'h0;
    int          acc_cnt = 0;
    int          ovl_cnt = 0;
    int          mis_cnt = 0;
    bit          apb_log[$];

    axi_lite_to_apb_bridge #(.AddrWidth(32), .DataWidth(32), .TimeoutCycles(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .aw_addr_i(aw_addr), .aw_prot_i(aw_prot), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
        .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready),
        .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
        .ar_addr_i(ar_addr), .ar_prot_i(ar_prot), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
        .r_data_o(r_data), .r_resp_o(r_resp), .r_valid_o(r_valid), .r_ready_i(r_ready),
        .paddr_o(paddr), .pprot_o(pprot), .psel_o(psel), .penable_o(penable),
        .pwrite_o(pwrite), .pwdata_o(pwdata), .pstrb_o(pstrb),
        .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
    );

    always #5 clk_i = ~clk_i;

    // APB completer: inserts cfg_wait wait states, or never answers when cfg_hang is set.
    always @(posedge clk_i) begin
        #1;
        if (psel && penable) begin
            pready  = !cfg_hang && (acc_cnt >= cfg_wait);
            prdata  = cfg_rdata;
            pslverr = cfg_err;
            acc_cnt++;
        end else begin
            pready  = 1'b0;
            prdata  = 32'h0;
            pslverr = 1'b0;
            acc_cnt = 0;
        end
    end

    always @(negedge clk_i) begin
        if (psel && penable && pready) apb_log.push_back(pwrite);
        if (aw_ready && ar_ready) ovl_cnt++;
        if (aw_ready != w_ready) mis_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Entered and left at posedge+1; leaves in the SETUP cycle of the granted transfer.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        aw_addr = a; aw_prot = 3'b000; w_data = d; w_strb = s;
        aw_valid = 1'b1; w_valid = 1'b1;
        #2;
        while (!aw_ready && n < 100) begin cyc(); #2; n++; end
        check("aw_handshake", 32'(n < 100), 32'd1);
        cyc();
        aw_valid = 1'b0; w_valid = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a);
        int n = 0;
        ar_addr = a; ar_prot = 3'b001; ar_valid = 1'b1;
        #2;
        while (!ar_ready && n < 100) begin cyc(); #2; n++; end
        check("ar_handshake", 32'(n < 100), 32'd1);
        cyc();
        ar_valid = 1'b0;
    endtask

    // Entered at posedge+1; returns at posedge+3 of the first cycle the response is valid.
    task automatic wait_resp(input bit wr, output int pen);
        int n = 0;
        pen = 0;
        #2;
        while (((wr ? b_valid : r_valid) == 1'b0) && n < 40) begin
            if (penable) pen++;
            cyc(); #2; n++;
        end
        check(wr ? "b_resp_wait" : "r_resp_wait", 32'(n < 40), 32'd1);
    endtask

    initial begin
        int pen, viol, bviol, log_before;
        bit got_r;
        logic [31:0] rd_s;
        bit exp_wr;

        rst_i = 1'b1;
        aw_addr = '0; aw_prot = '0; aw_valid = 1'b0; w_data = '0; w_strb = '0; w_valid = 1'b0;
        ar_addr = '0; ar_prot = '0; ar_valid = 1'b0; b_ready = 1'b0; r_ready = 1'b0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        repeat (2) cyc();
        #2;
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_b_valid", 32'(b_valid), 32'd0);
        check("rst_r_valid", 32'(r_valid), 32'd0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_r_data", r_data, 32'h0);
        cyc();
        rst_i = 1'b0;

        // Zero-wait write
        aw_addr = 32'h100; aw_prot = 3'b000; w_data = 32'hDEAD_BEEF; w_strb = 4'hF;
        aw_valid = 1'b1; w_valid = 1'b1;
        #2;
        check("t1_aw_ready", 32'(aw_ready), 32'd1);
        check("t1_w_ready", 32'(w_ready), 32'd1);
        check("t1_ar_ready", 32'(ar_ready), 32'd0);
        cyc();
        aw_valid = 1'b0; w_valid = 1'b0;
        #2;
        check("t1_setup_psel", 32'(psel), 32'd1);
        check("t1_setup_penable", 32'(penable), 32'd0);
        check("t1_paddr", paddr, 32'h100);
        check("t1_pwrite", 32'(pwrite), 32'd1);
        check("t1_pstrb", 32'(pstrb), 32'hF);
        check("t1_pwdata", pwdata, 32'hDEAD_BEEF);
        cyc(); #2;
        check("t1_access_penable", 32'(penable), 32'd1);
        check("t1_b_early", 32'(b_valid), 32'd0);
        cyc(); #2;
        check("t1_b_valid", 32'(b_valid), 32'd1);
        check("t1_b_resp", 32'(b_resp), 32'd0);
        check("t1_psel_drop", 32'(psel), 32'd0);
        b_ready = 1'b1;
        cyc(); #2;
        check("t1_b_drained", 32'(b_valid), 32'd0);
        cyc();

        // Read with 4 wait states and slave error
        cfg_wait = 4; cfg_err = 1'b1; cfg_rdata = 32'h1234_5678; r_ready = 1'b0;
        axi_read(32'h204);
        wait_resp(1'b0, pen);
        check("t2_penable_cycles", 32'(pen), 32'd5);
        check("t2_r_data", r_data, 32'h1234_5678);
        check("t2_r_resp", 32'(r_resp), 32'h2);
        check("t2_paddr", paddr, 32'h204);
        check("t2_pprot", 32'(pprot), 32'd1);
        check("t2_pstrb", 32'(pstrb), 32'd0);
        r_ready = 1'b1;
        cyc();

        // Simultaneous write and read streams alternate on APB
        cfg_wait = 0; cfg_err = 1'b0; b_ready = 1'b1; r_ready = 1'b1;
        apb_log.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) axi_write(32'h1000 + 32'(i * 4), 32'(i), 4'hF);
            end
            begin
                for (int j = 0; j < 4; j++) axi_read(32'h2000 + 32'(j * 4));
            end
        join
        repeat (5) cyc();
        check("t3_log_len", 32'(apb_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < apb_log.size(); k++) begin
            exp_wr = (k % 2 == 0);
            check("t3_order", 32'(apb_log[k]), 32'(exp_wr));
        end

        // Held B buffer blocks writes only
        b_ready = 1'b0; cfg_err = 1'b1;
        axi_write(32'h300, 32'h1111_2222, 4'h3);
        wait_resp(1'b1, pen);
        check("t4_b1_resp", 32'(b_resp), 32'h2);
        cfg_err = 1'b0; cfg_rdata = 32'hCAFE_F00D;
        cyc();
        aw_addr = 32'h304; w_data = 32'h3333_4444; w_strb = 4'hF; aw_valid = 1'b1; w_valid = 1'b1;
        ar_addr = 32'h400; ar_valid = 1'b1;
        #2;
        check("t4_aw_blocked", 32'(aw_ready), 32'd0);
        check("t4_ar_granted", 32'(ar_ready), 32'd1);
        cyc();
        ar_valid = 1'b0;
        log_before = apb_log.size();
        viol = 0; bviol = 0; got_r = 1'b0; rd_s = '0;
        repeat (6) begin
            #2;
            if (aw_ready) viol++;
            if (!b_valid || b_resp != 2'b10) bviol++;
            if (r_valid && !got_r) begin got_r = 1'b1; rd_s = r_data; end
            cyc();
        end
        check("t4_aw_stall", 32'(viol), 32'd0);
        check("t4_b_stable", 32'(bviol), 32'd0);
        check("t4_r_seen", 32'(got_r), 32'd1);
        check("t4_r_data", rd_s, 32'hCAFE_F00D);
        check("t4_one_apb", 32'(apb_log.size() - log_before), 32'd1);
        b_ready = 1'b1;
        axi_write(32'h304, 32'h3333_4444, 4'hF);
        #2;
        check("t4_w2_paddr", paddr, 32'h304);
        cyc();
        wait_resp(1'b1, pen);
        check("t4_b2_resp", 32'(b_resp), 32'd0);
        cyc();

        // Watchdog expiry on a hung read
        cfg_hang = 1'b1; r_ready = 1'b0;
        axi_read(32'h500);
        wait_resp(1'b0, pen);
        check("t5_access_cycles", 32'(pen), 32'd8);
        check("t5_r_resp", 32'(r_resp), 32'h2);
        check("t5_r_data", r_data, 32'h0);
        check("t5_psel", 32'(psel), 32'd0);
        cfg_hang = 1'b0;
        aw_addr = 32'h504; w_data = 32'h5555_6666; w_strb = 4'hF; aw_valid = 1'b1; w_valid = 1'b1;
        #1;
        check("t5_next_accept", 32'(aw_ready), 32'd1);
        cyc();
        aw_valid = 1'b0; w_valid = 1'b0;
        #2;
        check("t5_next_setup", 32'(psel), 32'd1);
        check("t5_next_paddr", paddr, 32'h504);
        cyc();
        wait_resp(1'b1, pen);
        check("t5_b_resp", 32'(b_resp), 32'd0);
        r_ready = 1'b1;
        cyc();

        // Reset in the middle of an ACCESS phase
        cfg_wait = 3;
        axi_write(32'h600, 32'hA5A5_5A5A, 4'hF);
        log_before = apb_log.size();
        cyc(); #2;
        check("t6_in_access", 32'(penable), 32'd1);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        #2;
        check("t6_psel", 32'(psel), 32'd0);
        check("t6_penable", 32'(penable), 32'd0);
        check("t6_b_valid", 32'(b_valid), 32'd0);
        check("t6_paddr", paddr, 32'h0);
        check("t6_no_complete", 32'(apb_log.size() - log_before), 32'd0);
        cyc();
        cfg_wait = 0; cfg_rdata = 32'h0BAD_F00D; r_ready = 1'b0;
        axi_read(32'h700);
        wait_resp(1'b0, pen);
        check("t6_r_data", r_data, 32'h0BAD_F00D);
        check("t6_r_resp", 32'(r_resp), 32'd0);
        r_ready = 1'b1;
        cyc();

        check("ready_overlap", 32'(ovl_cnt), 32'd0);
        check("aw_w_ready_mismatch", 32'(mis_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
